// File: rtl/lockout_ctrl_pkg.sv
// Shared types, widths and 7-segment constants for the keypad lockout controller.
// Segment order is {g,f,e,d,c,b,a}; all patterns are active-low.
package lockout_ctrl_pkg;

    localparam int unsigned COMB_W  = 10;
    localparam int unsigned FAILS_W = 4;
    localparam int unsigned SECS_W  = 7;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_OPEN   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    typedef struct packed {
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] units;
    } bcd_t;

    localparam logic [SEG_W-1:0] BLANK_7SEG = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h10;

    // Tens/units split by threshold compares instead of a divider; valid up to 99.
    function automatic bcd_t bcd_split(input logic [SECS_W-1:0] v);
        bcd_t b;
        b.tens = '0;
        for (int i = 1; i <= 9; i++) begin
            if (v >= SECS_W'(i * 10)) begin
                b.tens = DIGIT_W'(i);
            end
        end
        b.units = DIGIT_W'(v - SECS_W'(b.tens) * SECS_W'(10));
        return b;
    endfunction

endpackage

// File: rtl/lockout_ctrl_if.sv
// Link between the password FSM side and the lockout controller.
// master = password FSM / keypad side, slave = lockout controller.
interface lockout_ctrl_if;
    import lockout_ctrl_pkg::*;

    logic                correct;
    logic                error;
    logic [COMB_W-1:0]   comb_in;
    logic [COMB_W-1:0]   comb_out;
    logic                locked;
    logic                opened;
    logic [FAILS_W-1:0]  fails;
    logic [SEG_W-1:0]    d_hi;
    logic [SEG_W-1:0]    d_lo;
    logic [SEG_W-1:0]    d_fail;

    modport master (
        output correct, error, comb_in,
        input  comb_out, locked, opened, fails, d_hi, d_lo, d_fail
    );

    modport slave (
        input  correct, error, comb_in,
        output comb_out, locked, opened, fails, d_hi, d_lo, d_fail
    );

endinterface

// File: rtl/lockout_ctrl_seg7_dec.sv
// BCD digit to active-low 7-segment pattern; any value above 9 blanks the digit.
module lockout_ctrl_seg7_dec
    import lockout_ctrl_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [SEG_W-1:0]   seg_c
);

    always_comb begin
        seg_c = BLANK_7SEG;
        case (digit)
            4'd0: seg_c = SEG_0;
            4'd1: seg_c = SEG_1;
            4'd2: seg_c = SEG_2;
            4'd3: seg_c = SEG_3;
            4'd4: seg_c = SEG_4;
            4'd5: seg_c = SEG_5;
            4'd6: seg_c = SEG_6;
            4'd7: seg_c = SEG_7;
            4'd8: seg_c = SEG_8;
            4'd9: seg_c = SEG_9;
            default: seg_c = BLANK_7SEG;
        endcase
    end

endmodule

// File: rtl/lockout_ctrl.sv
// Counts consecutive failed entries, locks the keypad with a countdown after too
// many, and holds an open indication after a correct entry. Single clock domain.
module lockout_ctrl
    import lockout_ctrl_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 10,
    parameter int unsigned MAX_FAILS     = 3,
    parameter int unsigned LOCK_SECS     = 30,
    parameter int unsigned OPEN_SECS     = 5
)(
    input  logic           clk,
    input  logic           rst,
    lockout_ctrl_if.slave  bus
);

    localparam int unsigned PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    state_t               state, state_nxt;
    logic [FAILS_W-1:0]   fails_q, fails_nxt;
    logic [SECS_W-1:0]    secs_q, secs_nxt;
    logic [PRESC_W-1:0]   presc_q, presc_nxt;
    logic                 tick_c;
    logic                 show_c;
    bcd_t                 bcd_c;
    logic [DIGIT_W-1:0]   hi_digit_c;
    logic [DIGIT_W-1:0]   lo_digit_c;
    logic [SEG_W-1:0]     hi_seg_c;
    logic [SEG_W-1:0]     lo_seg_c;
    logic [SEG_W-1:0]     fail_seg_c;

    assign tick_c = (state != ST_ARMED) && (presc_q == PRESC_W'(TICKS_PER_SEC - 1));

    // Next-state, fail counter and countdown; error takes priority over correct.
    always_comb begin
        state_nxt = state;
        fails_nxt = fails_q;
        secs_nxt  = secs_q;
        presc_nxt = presc_q;
        case (state)
            ST_ARMED: begin
                presc_nxt = '0;
                if (bus.error) begin
                    fails_nxt = fails_q + FAILS_W'(1);
                    if (fails_nxt == FAILS_W'(MAX_FAILS)) begin
                        state_nxt = ST_LOCKED;
                        secs_nxt  = SECS_W'(LOCK_SECS);
                    end
                end else if (bus.correct) begin
                    state_nxt = ST_OPEN;
                    secs_nxt  = SECS_W'(OPEN_SECS);
                    fails_nxt = '0;
                end
            end
            default: begin
                presc_nxt = tick_c ? '0 : presc_q + PRESC_W'(1);
                if (tick_c) begin
                    secs_nxt = secs_q - SECS_W'(1);
                    if (secs_q == SECS_W'(1)) begin
                        state_nxt = ST_ARMED;
                        presc_nxt = '0;
                        if (state == ST_LOCKED) begin
                            fails_nxt = '0;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_ARMED;
            fails_q <= '0;
        end else begin
            state   <= state_nxt;
            fails_q <= fails_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            secs_q  <= '0;
            presc_q <= '0;
        end else begin
            secs_q  <= secs_nxt;
            presc_q <= presc_nxt;
        end
    end

    // Display digits derived from next-state values so they line up with the state.
    assign show_c     = (state_nxt != ST_ARMED);
    assign bcd_c      = bcd_split(secs_nxt);
    assign hi_digit_c = (show_c && (bcd_c.tens != '0)) ? bcd_c.tens : 4'hF;
    assign lo_digit_c = show_c ? bcd_c.units : 4'hF;

    lockout_ctrl_seg7_dec u_dec_hi (
        .digit (hi_digit_c),
        .seg_c (hi_seg_c)
    );

    lockout_ctrl_seg7_dec u_dec_lo (
        .digit (lo_digit_c),
        .seg_c (lo_seg_c)
    );

    lockout_ctrl_seg7_dec u_dec_fail (
        .digit (fails_nxt),
        .seg_c (fail_seg_c)
    );

    // Output registers; keypad pulses are dropped whenever the next state is LOCKED.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.locked   <= 1'b0;
            bus.opened   <= 1'b0;
            bus.fails    <= '0;
            bus.comb_out <= '0;
            bus.d_hi     <= BLANK_7SEG;
            bus.d_lo     <= BLANK_7SEG;
            bus.d_fail   <= SEG_0;
        end else begin
            bus.locked   <= (state_nxt == ST_LOCKED);
            bus.opened   <= (state_nxt == ST_OPEN);
            bus.fails    <= fails_nxt;
            bus.comb_out <= (state_nxt == ST_LOCKED) ? '0 : bus.comb_in;
            bus.d_hi     <= hi_seg_c;
            bus.d_lo     <= lo_seg_c;
            bus.d_fail   <= fail_seg_c;
        end
    end

endmodule

// File: tb/tb_lockout_ctrl.sv
// Directed bench for lockout_ctrl with TICKS_PER_SEC=2, MAX_FAILS=3, LOCK_SECS=5,
// OPEN_SECS=3: vector tables for single-cycle steps plus loops for the countdowns.
module tb_lockout_ctrl;

    localparam logic [6:0] BLK = 7'h7F;

    typedef struct {
        string       name;
        logic        rst;
        logic        correct;
        logic        error;
        logic [9:0]  comb_in;
        logic        locked;
        logic        opened;
        logic [3:0]  fails;
        logic [6:0]  d_hi;
        logic [6:0]  d_lo;
        logic [9:0]  comb_out;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    lockout_ctrl_if bus ();

    lockout_ctrl #(
        .TICKS_PER_SEC (2),
        .MAX_FAILS     (3),
        .LOCK_SECS     (5),
        .OPEN_SECS     (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return BLK;
        endcase
    endfunction

    function automatic vec_t mk(input string n, input logic r, input logic c, input logic e,
                                input logic [9:0] ci, input logic lk, input logic op,
                                input logic [3:0] f, input logic [6:0] hi, input logic [6:0] lo,
                                input logic [9:0] co);
        vec_t v;
        v.name = n;  v.rst = r;  v.correct = c;  v.error = e;  v.comb_in = ci;
        v.locked = lk;  v.opened = op;  v.fails = f;  v.d_hi = hi;  v.d_lo = lo;
        v.comb_out = co;
        return v;
    endfunction

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then compare every output just after the edge.
    task automatic apply(input vec_t v);
        rst         = v.rst;
        bus.correct = v.correct;
        bus.error   = v.error;
        bus.comb_in = v.comb_in;
        @(posedge clk);
        #1;
        chk({v.name, ".locked"},   16'(bus.locked),   16'(v.locked));
        chk({v.name, ".opened"},   16'(bus.opened),   16'(v.opened));
        chk({v.name, ".fails"},    16'(bus.fails),    16'(v.fails));
        chk({v.name, ".d_hi"},     16'(bus.d_hi),     16'(v.d_hi));
        chk({v.name, ".d_lo"},     16'(bus.d_lo),     16'(v.d_lo));
        chk({v.name, ".d_fail"},   16'(bus.d_fail),   16'(seg(int'(v.fails))));
        chk({v.name, ".comb_out"}, 16'(bus.comb_out), 16'(v.comb_out));
    endtask

    vec_t tbl_lock[$];
    vec_t tbl_open[$];
    vec_t tbl_tie[$];

    initial begin
        rst         = 1'b1;
        bus.correct = 1'b0;
        bus.error   = 1'b0;
        bus.comb_in = '0;

        //                   name       rst c  e  comb_in  lk op f  d_hi d_lo    comb_out
        tbl_lock.push_back(mk("reset",   1, 0, 0, 10'h000, 0, 0, 0, BLK, BLK,    10'h000));
        tbl_lock.push_back(mk("idle",    0, 0, 0, 10'h155, 0, 0, 0, BLK, BLK,    10'h155));
        tbl_lock.push_back(mk("err1",    0, 0, 1, 10'h000, 0, 0, 1, BLK, BLK,    10'h000));
        tbl_lock.push_back(mk("hold1",   0, 0, 0, 10'h000, 0, 0, 1, BLK, BLK,    10'h000));
        tbl_lock.push_back(mk("err2",    0, 0, 1, 10'h001, 0, 0, 2, BLK, BLK,    10'h001));
        tbl_lock.push_back(mk("err3",    0, 0, 1, 10'h3FF, 1, 0, 3, BLK, seg(5), 10'h000));

        tbl_open.push_back(mk("o_err1",  0, 0, 1, 10'h000, 0, 0, 1, BLK, BLK,    10'h000));
        tbl_open.push_back(mk("o_err2",  0, 0, 1, 10'h000, 0, 0, 2, BLK, BLK,    10'h000));
        tbl_open.push_back(mk("o_corr",  0, 1, 0, 10'h2A5, 0, 1, 0, BLK, seg(3), 10'h2A5));

        tbl_tie.push_back(mk("t_err1",   0, 0, 1, 10'h000, 0, 0, 1, BLK, BLK,    10'h000));
        tbl_tie.push_back(mk("t_err2",   0, 0, 1, 10'h000, 0, 0, 2, BLK, BLK,    10'h000));
        tbl_tie.push_back(mk("t_both",   0, 1, 1, 10'h0F0, 1, 0, 3, BLK, seg(5), 10'h000));

        // Reset, three errors into lockout.
        for (int i = 0; i < tbl_lock.size(); i++) apply(tbl_lock[i]);

        // Lockout countdown: ten cycles, correct/error ignored, keypad gated.
        for (int k = 1; k <= 10; k++) begin
            if (k < 10)
                apply(mk($sformatf("lock_k%0d", k), 0, (k == 3), (k == 5), 10'h3FF,
                         1, 0, 3, BLK, seg(5 - k / 2), 10'h000));
            else
                apply(mk("lock_end", 0, 0, 0, 10'h3FF, 0, 0, 0, BLK, BLK, 10'h3FF));
        end
        apply(mk("post_lock", 0, 0, 0, 10'h0AA, 0, 0, 0, BLK, BLK, 10'h0AA));

        // Two errors then correct: open for six cycles, error during open ignored.
        for (int i = 0; i < tbl_open.size(); i++) apply(tbl_open[i]);
        for (int k = 1; k <= 6; k++) begin
            if (k < 6)
                apply(mk($sformatf("open_k%0d", k), 0, 0, (k == 2), 10'h000,
                         0, 1, 0, BLK, seg(3 - k / 2), 10'h000));
            else
                apply(mk("open_end", 0, 0, 0, 10'h000, 0, 0, 0, BLK, BLK, 10'h000));
        end

        // Simultaneous correct+error with fails=2: error wins.
        for (int i = 0; i < tbl_tie.size(); i++) apply(tbl_tie[i]);

        // Run to secs=3, then reset mid-lock.
        for (int k = 1; k <= 4; k++)
            apply(mk($sformatf("mid_k%0d", k), 0, 0, 0, 10'h3FF,
                     1, 0, 3, BLK, seg(5 - k / 2), 10'h000));
        apply(mk("mid_rst",   1, 0, 0, 10'h3FF, 0, 0, 0, BLK, BLK, 10'h000));
        apply(mk("after_rst", 0, 0, 0, 10'h3FF, 0, 0, 0, BLK, BLK, 10'h3FF));
        apply(mk("rst_err",   0, 0, 1, 10'h000, 0, 0, 1, BLK, BLK, 10'h000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
